regfile_flush_ctrl: RTL

- Sequences register-file recovery after a pipeline flush in the out-of-order core.
- Snapshots the 8-entry ROB's busy/destination state and drives the regfile's flush_ip, set_reg_valid and reg_valid inputs.
- Gates the regfile allocate and load ports while recovery is in progress.
- Reports completion to the front end and ROB with a one-cycle done pulse.

---
 rtl/regfile_flush_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_flush_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_flush_ctrl
//
// Sequences register-file recovery after a full pipeline flush. When a flush
// request arrives, the ROB busy/destination state is snapshotted, replayed to
// the regfile as a one-cycle restore strobe, and then allocate stays blocked for
// DRAIN_CYCLES cycles so in-flight CDB traffic can clear. A one-cycle done pulse
// marks the end of the sequence.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush_req_i         one-cycle flush request pulse
//   rob_busy_i          per-entry ROB busy flags
//   rob_dest_i          per-entry ROB destination register (5 bits each)
//   alloc_in_i          allocate request from the instruction queue
//   load_in_i           commit load request from the ROB
//   alloc_out_o         gated allocate to the regfile
//   load_out_o          gated load to the regfile
//   flush_ip_o          flush-in-progress strobe (RESTORE only)
//   set_reg_valid_o     restore enables (RESTORE only)
//   reg_valid_o         registers to restore (RESTORE only)
//   busy_o              high whenever the sequencer is not IDLE
//   flush_done_o        one-cycle completion pulse
//   err_drop_o          sticky: a load was dropped while recovering
// -----------------------------------------------------------------------------
module regfile_flush_ctrl #(
    parameter int ROB_DEPTH    = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_req_i,
    input  logic [ROB_DEPTH-1:0]      rob_busy_i,
    input  logic [ROB_DEPTH-1:0][4:0] rob_dest_i,
    input  logic                      alloc_in_i,
    input  logic                      load_in_i,
    output logic                      alloc_out_o,
    output logic                      load_out_o,
    output logic                      flush_ip_o,
    output logic [ROB_DEPTH-1:0]      set_reg_valid_o,
    output logic [ROB_DEPTH-1:0][4:0] reg_valid_o,
    output logic                      busy_o,
    output logic                      flush_done_o,
    output logic                      err_drop_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_RESTORE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Counter reload value: DRAIN lasts DRAIN_CYCLES cycles counting down to 0.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_e                      state_q, state_d;
    logic [ROB_DEPTH-1:0]        snap_en_q, snap_en_d;
    logic [ROB_DEPTH-1:0][4:0]   snap_dest_q, snap_dest_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic                        pending_q, pending_d;
    logic                        err_q, err_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: state_d = ST_RESTORE;
            ST_RESTORE: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                // A flush that arrived during recovery, or one coinciding with
                // DONE itself, restarts the sequence without passing IDLE.
                if (pending_q || flush_req_i) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: snapshot, drain counter, pending flush, dropped-load flag.
    always_comb begin
        snap_en_d   = snap_en_q;
        snap_dest_d = snap_dest_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        err_d       = err_q;

        if (state_q == ST_CAPTURE) begin
            snap_dest_d = rob_dest_i;
            // x0 is hard-wired, so it is never restored.
            for (int i = 0; i < ROB_DEPTH; i++) begin
                snap_en_d[i] = rob_busy_i[i] & (rob_dest_i[i] != 5'd0);
            end
        end else begin
            snap_en_d   = snap_en_q;
            snap_dest_d = snap_dest_q;
        end

        if (state_q == ST_RESTORE) begin
            cnt_d = DRAIN_LOAD;
        end else if ((state_q == ST_DRAIN) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end

        // DONE consumes the pending request; requests collapse into one.
        if (state_q == ST_DONE) begin
            pending_d = 1'b0;
        end else if ((state_q != ST_IDLE) && flush_req_i) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        if (load_in_i && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_en_q   <= '0;
            snap_dest_q <= '0;
            cnt_q       <= 4'd0;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            snap_en_q   <= snap_en_d;
            snap_dest_q <= snap_dest_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
        end
    end

    // Output decode; gating is combinational so it acts in the request cycle.
    always_comb begin
        alloc_out_o     = 1'b0;
        load_out_o      = 1'b0;
        flush_ip_o      = 1'b0;
        set_reg_valid_o = '0;
        reg_valid_o     = '0;
        flush_done_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A same-cycle load still commits (the mispredicting
                // instruction), but allocate is blocked at once.
                alloc_out_o = alloc_in_i & ~flush_req_i;
                load_out_o  = load_in_i;
            end
            ST_RESTORE: begin
                flush_ip_o      = 1'b1;
                set_reg_valid_o = snap_en_q;
                reg_valid_o     = snap_dest_q;
            end
            ST_DONE: flush_done_o = 1'b1;
            default: begin
                alloc_out_o  = 1'b0;
                flush_done_o = 1'b0;
            end
        endcase
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign err_drop_o = err_q;

endmodule
